mdc8p_frame_ctrl: RTL and testbench

MDC8P_FRAME_CTRL -- requirements
Module: mdc8p_frame_ctrl

---
 rtl/mdc8p_frame_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mdc8p_frame_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdc8p_frame_ctrl.sv
// Frame controller around a 2-sample-per-beat MDC FFT: frames/pads upstream beats into the FFT
// and tags FFT output frames with sof/eof/bad using a status FIFO of frames in flight.
module mdc8p_frame_ctrl #(
  parameter int unsigned NB_IN     = 8,
  parameter int unsigned NB_OUT    = 10,
  parameter int unsigned FRAME_CYC = 4,
  parameter int unsigned N_FLIGHT  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_sof,
  input  logic              i_inverse,
  input  logic [NB_IN-1:0]  i_data1_r,
  input  logic [NB_IN-1:0]  i_data1_i,
  input  logic [NB_IN-1:0]  i_data2_r,
  input  logic [NB_IN-1:0]  i_data2_i,
  output logic              o_ready,
  output logic              o_fft_valid,
  output logic              o_fft_inverse,
  output logic [NB_IN-1:0]  o_fft_data1_r,
  output logic [NB_IN-1:0]  o_fft_data1_i,
  output logic [NB_IN-1:0]  o_fft_data2_r,
  output logic [NB_IN-1:0]  o_fft_data2_i,
  input  logic              i_fft_valid,
  input  logic [NB_OUT-1:0] i_fft_data1_r,
  input  logic [NB_OUT-1:0] i_fft_data1_i,
  input  logic [NB_OUT-1:0] i_fft_data2_r,
  input  logic [NB_OUT-1:0] i_fft_data2_i,
  output logic              o_valid,
  output logic              o_sof,
  output logic              o_eof,
  output logic              o_bad,
  output logic [NB_OUT-1:0] o_data1_r,
  output logic [NB_OUT-1:0] o_data1_i,
  output logic [NB_OUT-1:0] o_data2_r,
  output logic [NB_OUT-1:0] o_data2_i,
  output logic              o_err_orphan,
  output logic              o_err_spurious
);

  localparam int unsigned BW = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
  localparam int unsigned PW = (N_FLIGHT > 1) ? $clog2(N_FLIGHT) : 1;
  localparam int unsigned CW = $clog2(N_FLIGHT + 1);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(FRAME_CYC - 1);
  localparam logic [CW-1:0] MAX_FLIGHT = CW'(N_FLIGHT);
  localparam logic [PW-1:0] LAST_PTR   = PW'(N_FLIGHT - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAD} state_t;

  state_t              r_state;
  logic [BW-1:0]       r_beat;
  logic [BW-1:0]       r_obeat;
  logic [CW-1:0]       r_inflight;
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [N_FLIGHT-1:0] r_fifo_bad;
  logic                r_inv;
  logic                r_bad;

  logic          w_accept;
  logic          w_fwd;
  logic          w_fwd_zero;
  logic          w_fwd_bad;
  logic [BW-1:0] w_fwd_idx;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;

  // A new frame may only join the FFT pipeline if it shares the in-flight transform direction.
  always_comb begin
    o_ready = 1'b0;
    unique case (r_state)
      IDLE:    o_ready = (r_inflight < MAX_FLIGHT) && ((r_inflight == '0) || (i_inverse == r_inv));
      RUN:     o_ready = 1'b1;
      default: o_ready = 1'b0;
    endcase
  end

  assign w_accept = i_valid & o_ready;

  always_comb begin
    w_fwd      = 1'b0;
    w_fwd_zero = 1'b0;
    w_fwd_bad  = r_bad;
    w_fwd_idx  = r_beat;
    unique case (r_state)
      IDLE: begin
        w_fwd     = w_accept & i_sof;
        w_fwd_bad = 1'b0;
        w_fwd_idx = '0;
      end
      RUN: begin
        w_fwd      = 1'b1;
        w_fwd_zero = ~i_valid;
        w_fwd_bad  = r_bad | ~i_valid | i_sof;
      end
      PAD: begin
        w_fwd      = 1'b1;
        w_fwd_zero = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_push  = w_fwd && (w_fwd_idx == LAST_BEAT);
  assign w_empty = (r_inflight == '0);
  assign w_pop   = i_fft_valid && (r_obeat == LAST_BEAT) && !w_empty;

  assign o_fft_inverse = r_inv;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= IDLE;
      r_beat         <= '0;
      r_obeat        <= '0;
      r_inflight     <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_inv          <= 1'b0;
      r_bad          <= 1'b0;
      o_fft_valid    <= 1'b0;
      o_err_orphan   <= 1'b0;
      o_valid        <= 1'b0;
      o_sof          <= 1'b0;
      o_eof          <= 1'b0;
      o_bad          <= 1'b0;
      o_err_spurious <= 1'b0;
    end else begin
      o_fft_valid  <= w_fwd;
      o_err_orphan <= (r_state == IDLE) && w_accept && !i_sof;
      if (w_fwd) begin
        o_fft_data1_r <= w_fwd_zero ? '0 : i_data1_r;
        o_fft_data1_i <= w_fwd_zero ? '0 : i_data1_i;
        o_fft_data2_r <= w_fwd_zero ? '0 : i_data2_r;
        o_fft_data2_i <= w_fwd_zero ? '0 : i_data2_i;
        r_bad         <= w_fwd_bad;
        if (r_state == IDLE) r_inv <= i_inverse;
      end
      if (w_push) begin
        r_state  <= IDLE;
        r_beat   <= '0;
        r_fifo_bad[r_wr_ptr] <= w_fwd_bad;
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end else if (w_fwd) begin
        r_state <= w_fwd_zero ? PAD : RUN;
        r_beat  <= w_fwd_idx + 1'b1;
      end

      o_valid        <= i_fft_valid;
      o_sof          <= i_fft_valid && (r_obeat == '0);
      o_eof          <= i_fft_valid && (r_obeat == LAST_BEAT);
      o_bad          <= i_fft_valid && (w_empty || r_fifo_bad[r_rd_ptr]);
      o_err_spurious <= i_fft_valid && w_empty;
      if (i_fft_valid) begin
        o_data1_r <= i_fft_data1_r;
        o_data1_i <= i_fft_data1_i;
        o_data2_r <= i_fft_data2_r;
        o_data2_i <= i_fft_data2_i;
        r_obeat   <= (r_obeat == LAST_BEAT) ? '0 : r_obeat + 1'b1;
      end
      if (w_pop) r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;

      // Simultaneous push and pop leaves the count alone.
      unique case ({w_push, w_pop})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdc8p_frame_ctrl.sv
// Bench for mdc8p_frame_ctrl: directed frame scenarios, a delayed pass-through FFT stand-in,
// and a frame-level reference model checked every cycle.
module tb_mdc8p_frame_ctrl;

  localparam int unsigned NB_IN     = 8;
  localparam int unsigned NB_OUT    = 10;
  localparam int unsigned FRAME_CYC = 4;
  localparam int unsigned N_FLIGHT  = 4;
  localparam int          FFT_LAT   = 12;

  logic i_clk, i_rst, i_valid, i_sof, i_inverse, i_fft_valid;
  logic [NB_IN-1:0] i_data1_r, i_data1_i, i_data2_r, i_data2_i;
  logic [NB_IN-1:0] o_fft_data1_r, o_fft_data1_i, o_fft_data2_r, o_fft_data2_i;
  logic [NB_OUT-1:0] i_fft_data1_r, i_fft_data1_i, i_fft_data2_r, i_fft_data2_i;
  logic [NB_OUT-1:0] o_data1_r, o_data1_i, o_data2_r, o_data2_i;
  logic o_ready, o_fft_valid, o_fft_inverse, o_valid, o_sof, o_eof, o_bad;
  logic o_err_orphan, o_err_spurious;

  mdc8p_frame_ctrl #(
    .NB_IN(NB_IN), .NB_OUT(NB_OUT), .FRAME_CYC(FRAME_CYC), .N_FLIGHT(N_FLIGHT)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_sof(i_sof), .i_inverse(i_inverse),
    .i_data1_r(i_data1_r), .i_data1_i(i_data1_i), .i_data2_r(i_data2_r), .i_data2_i(i_data2_i),
    .o_ready(o_ready), .o_fft_valid(o_fft_valid), .o_fft_inverse(o_fft_inverse),
    .o_fft_data1_r(o_fft_data1_r), .o_fft_data1_i(o_fft_data1_i),
    .o_fft_data2_r(o_fft_data2_r), .o_fft_data2_i(o_fft_data2_i),
    .i_fft_valid(i_fft_valid),
    .i_fft_data1_r(i_fft_data1_r), .i_fft_data1_i(i_fft_data1_i),
    .i_fft_data2_r(i_fft_data2_r), .i_fft_data2_i(i_fft_data2_i),
    .o_valid(o_valid), .o_sof(o_sof), .o_eof(o_eof), .o_bad(o_bad),
    .o_data1_r(o_data1_r), .o_data1_i(o_data1_i), .o_data2_r(o_data2_r), .o_data2_i(o_data2_i),
    .o_err_orphan(o_err_orphan), .o_err_spurious(o_err_spurious)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit stall = 0;
  logic [4*NB_OUT-1:0] fq[$];
  int ft[$];

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // FFT stand-in: each captured input beat re-emerges FFT_LAT cycles later, sign-extended + 3.
  initial begin : fft_model
    int cyc;
    int tmp;
    logic [4*NB_OUT-1:0] w;
    cyc = 0;
    i_fft_valid = 1'b0;
    {i_fft_data1_r, i_fft_data1_i, i_fft_data2_r, i_fft_data2_i} = '0;
    forever begin
      @(posedge i_clk);
      #1;
      cyc++;
      if (o_fft_valid === 1'b1) begin
        fq.push_back({NB_OUT'($signed(o_fft_data1_r)) + NB_OUT'(3),
                      NB_OUT'($signed(o_fft_data1_i)) + NB_OUT'(3),
                      NB_OUT'($signed(o_fft_data2_r)) + NB_OUT'(3),
                      NB_OUT'($signed(o_fft_data2_i)) + NB_OUT'(3)});
        ft.push_back(cyc);
      end
      if (!stall && fq.size() > 0 && (cyc - ft[0]) >= FFT_LAT) begin
        w = fq.pop_front();
        tmp = ft.pop_front();
        i_fft_valid = 1'b1;
        {i_fft_data1_r, i_fft_data1_i, i_fft_data2_r, i_fft_data2_i} = w;
      end else begin
        i_fft_valid = 1'b0;
      end
    end
  end

  // Reference model: frame position, pad flag and a queue of per-frame bad bits.
  int  m_pos = -1;
  bit  m_pad, m_bad, m_inv;
  bit  mq[$];
  int  m_obeat;
  bit  live = 0;
  bit  e_fv, e_finv, e_orph, e_v, e_sof, e_eof, e_bad, e_spur;
  logic [NB_IN-1:0]  e_fd1r, e_fd1i, e_fd2r, e_fd2i;
  logic [NB_OUT-1:0] e_d1r, e_d1i, e_d2r, e_d2i;

  function automatic bit m_ready();
    if (m_pos < 0) return (mq.size() < N_FLIGHT) && (mq.size() == 0 || i_inverse == m_inv);
    return !m_pad;
  endfunction

  initial begin : compare
    bit rdy;
    bit dummy;
    int idx;
    forever begin
      @(negedge i_clk);
      if (live) begin
        chk("fft_valid", o_fft_valid, e_fv);
        if (e_fv) begin
          chk("fft_data1_r", o_fft_data1_r, e_fd1r);
          chk("fft_data1_i", o_fft_data1_i, e_fd1i);
          chk("fft_data2_r", o_fft_data2_r, e_fd2r);
          chk("fft_data2_i", o_fft_data2_i, e_fd2i);
        end
        chk("fft_inverse", o_fft_inverse, e_finv);
        chk("err_orphan", o_err_orphan, e_orph);
        chk("out_valid", o_valid, e_v);
        chk("out_sof", o_sof, e_sof);
        chk("out_eof", o_eof, e_eof);
        chk("out_bad", o_bad, e_bad);
        chk("err_spurious", o_err_spurious, e_spur);
        if (e_v) begin
          chk("out_data1_r", o_data1_r, e_d1r);
          chk("out_data1_i", o_data1_i, e_d1i);
          chk("out_data2_r", o_data2_r, e_d2r);
          chk("out_data2_i", o_data2_i, e_d2i);
        end
        chk("ready", o_ready, m_ready());
      end
      // Predict the outputs registered at the coming edge.
      if (i_rst) begin
        m_pos = -1; m_pad = 0; m_bad = 0; m_inv = 0; m_obeat = 0;
        mq.delete();
        {e_fv, e_finv, e_orph, e_v, e_sof, e_eof, e_bad, e_spur} = '0;
        live = 1;
      end else begin
        rdy = m_ready();
        idx = -1;
        e_fv = 0;
        e_orph = 0;
        if (m_pos < 0) begin
          if (i_valid && rdy) begin
            if (i_sof) begin
              m_inv = i_inverse; m_bad = 0; idx = 0; e_fv = 1;
              {e_fd1r, e_fd1i, e_fd2r, e_fd2i} = {i_data1_r, i_data1_i, i_data2_r, i_data2_i};
            end else begin
              e_orph = 1;
            end
          end
        end else if (m_pad || !i_valid) begin
          m_pad = 1; m_bad = 1; idx = m_pos; e_fv = 1;
          {e_fd1r, e_fd1i, e_fd2r, e_fd2i} = '0;
        end else begin
          if (i_sof) m_bad = 1;
          idx = m_pos; e_fv = 1;
          {e_fd1r, e_fd1i, e_fd2r, e_fd2i} = {i_data1_r, i_data1_i, i_data2_r, i_data2_i};
        end
        e_finv = m_inv;
        e_v = i_fft_valid; e_sof = 0; e_eof = 0; e_bad = 0; e_spur = 0;
        if (i_fft_valid) begin
          e_sof = (m_obeat == 0);
          e_eof = (m_obeat == FRAME_CYC - 1);
          {e_d1r, e_d1i, e_d2r, e_d2i} = {i_fft_data1_r, i_fft_data1_i, i_fft_data2_r, i_fft_data2_i};
          if (mq.size() == 0) begin
            e_bad = 1; e_spur = 1;
          end else begin
            e_bad = mq[0];
            if (e_eof) dummy = mq.pop_front();
          end
          m_obeat = (m_obeat + 1) % FRAME_CYC;
        end
        if (idx >= 0) begin
          m_pos = idx + 1;
          if (m_pos == FRAME_CYC) begin
            mq.push_back(m_bad);
            m_pos = -1;
            m_pad = 0;
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input logic s, input logic inv);
    i_valid = v; i_sof = s; i_inverse = inv;
    i_data1_r = NB_IN'($urandom); i_data1_i = NB_IN'($urandom);
    i_data2_r = NB_IN'($urandom); i_data2_i = NB_IN'($urandom);
  endtask

  task automatic send_frame(input logic inv, input string nm);
    bit acc;
    acc = 0;
    drive(1, 1, inv);
    for (int k = 0; k < 80 && !acc; k++) begin
      #1;
      acc = o_ready;
      tick();
    end
    chk({nm, "_accept"}, acc, 1);
    for (int b = 1; b < FRAME_CYC; b++) begin
      drive(1, 0, inv);
      tick();
    end
    drive(0, 0, inv);
  endtask

  task automatic wait_out(input string nm, input bit want_spur);
    bit found;
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      tick();
      if (o_valid === 1'b1 && (want_spur ? o_err_spurious : o_sof) === 1'b1) found = 1;
    end
    chk({nm, "_seen"}, found, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (fq.size() == 0 && i_fft_valid !== 1'b1 && o_valid !== 1'b1) break;
      tick();
    end
    tick();
    tick();
  endtask

  // Waits for o_ready on a held sof beat; the beat is accepted at the edge after it is seen.
  task automatic hold_sof(input logic inv, input string nm, input bit expect_eof);
    bit got;
    got = 0;
    for (int k = 0; k < 80 && !got; k++) begin
      if (o_ready === 1'b1) begin
        got = 1;
        if (expect_eof) chk({nm, "_eof_with_ready"}, o_eof, 1);
      end
      tick();
      #1;
    end
    chk({nm, "_accept"}, got, 1);
    chk({nm, "_fft_valid"}, o_fft_valid, 1);
    chk({nm, "_fft_inverse"}, o_fft_inverse, inv);
    for (int b = 1; b < FRAME_CYC; b++) begin
      drive(1, 0, inv);
      tick();
    end
    drive(0, 0, inv);
  endtask

  initial begin : stimulus
    logic [NB_IN-1:0] d1r;
    i_rst = 1'b1;
    drive(0, 0, 0);
    repeat (3) tick();
    i_rst = 1'b0;

    // Reset state
    chk("lit_rst_fft_valid", o_fft_valid, 0);
    chk("lit_rst_valid", o_valid, 0);
    chk("lit_rst_orphan", o_err_orphan, 0);
    #1 chk("lit_rst_ready", o_ready, 1);

    // Clean frame, forward transform
    drive(1, 1, 0);
    d1r = i_data1_r;
    tick();
    chk("lit_s1_fft_valid", o_fft_valid, 1);
    chk("lit_s1_fft_inverse", o_fft_inverse, 0);
    chk("lit_s1_fft_data", o_fft_data1_r, d1r);
    for (int b = 1; b < FRAME_CYC; b++) begin
      drive(1, 0, 0);
      tick();
    end
    drive(0, 0, 0);
    wait_out("s1_out", 0);
    chk("lit_s1_bad", o_bad, 0);
    repeat (FRAME_CYC - 1) tick();
    chk("lit_s1_eof", o_eof, 1);
    drive(0, 0, 1);
    #1 chk("lit_s1_inflight_zero", o_ready, 1);
    drain();

    // Upstream gap after beat 1 -> padded frame
    drive(1, 1, 0); tick();
    drive(1, 0, 0); tick();
    drive(0, 0, 0); tick();
    drive(1, 0, 0);
    #1 chk("lit_pad_ready", o_ready, 0);
    chk("lit_pad_fft_valid", o_fft_valid, 1);
    chk("lit_pad_zero", o_fft_data1_r, 0);
    tick();
    drive(0, 0, 0);
    wait_out("s2_out", 0);
    chk("lit_pad_bad", o_bad, 1);
    drain();

    // Orphan beat in IDLE
    drive(1, 0, 0); tick();
    drive(0, 0, 0);
    chk("lit_orphan_pulse", o_err_orphan, 1);
    chk("lit_orphan_no_fwd", o_fft_valid, 0);
    tick();
    chk("lit_orphan_once", o_err_orphan, 0);

    // Direction change blocked until the in-flight frame pops
    send_frame(0, "s4_a");
    drive(1, 1, 1);
    #1 chk("lit_inv_block", o_ready, 0);
    hold_sof(1, "s4_b", 1);
    wait_out("s4_out", 0);
    chk("lit_s4_bad", o_bad, 0);
    drain();

    // FFT stalled: fill to N_FLIGHT, then refill one frame per pop
    stall = 1;
    for (int f = 0; f < N_FLIGHT; f++) send_frame(0, "fill");
    drive(1, 1, 0);
    #1 chk("lit_full_block", o_ready, 0);
    stall = 0;
    hold_sof(0, "s5_f5", 1);
    // Frame 5 completed on the same edge frame 2 popped: exactly one more slot remains.
    stall = 1;
    drive(1, 1, 0);
    #1 chk("lit_pushpop_ready", o_ready, 1);
    hold_sof(0, "s5_f6", 0);
    drive(1, 1, 0);
    #1 chk("lit_refill_block", o_ready, 0);
    stall = 0;
    send_frame(0, "s5_f7");
    drain();

    // Reset in the middle of a frame
    drive(1, 1, 0); tick();
    drive(1, 0, 0); tick();
    i_rst = 1'b1;
    drive(1, 0, 0);
    tick();
    i_rst = 1'b0;
    drive(0, 0, 0);
    chk("lit_midrst_fft_valid", o_fft_valid, 0);
    chk("lit_midrst_valid", o_valid, 0);
    chk("lit_midrst_sof", o_sof, 0);
    chk("lit_midrst_eof", o_eof, 0);
    chk("lit_midrst_bad", o_bad, 0);
    chk("lit_midrst_orphan", o_err_orphan, 0);
    chk("lit_midrst_spur", o_err_spurious, 0);
    chk("lit_midrst_inverse", o_fft_inverse, 0);
    wait_out("s6_spur", 1);
    chk("lit_spur_bad", o_bad, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
